// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO reader: FSM state encoding,
// default widths/depths and the burst beat-advance helper.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF   = 8;
  localparam int FIFO_DEPTH_DEF   = 8;
  localparam int READER_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_e;

  function automatic logic [7:0] beat_next(input logic [7:0] beat, input logic [7:0] beat_max);
    return (beat == beat_max) ? 8'd0 : beat + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order holding buffer for {last, data} words between the
// FIFO read port and the downstream valid/ready interface.
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int W = FIFO_WIDTH_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [READER_BUF_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;
  logic [1:0]   occ_d;

  // Caller guarantees no push when full (unless popping) and no pop when empty.
  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READER_BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from a registered-output FIFO and presents them as a
// valid/ready stream with burst markers. Optional word counter: FIFO_READER_CNT_EN.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
`ifdef FIFO_READER_CNT_EN
  output logic [15:0]      word_cnt,
`endif
  output reader_state_e    state_dbg
);

  // Handshake: a word moves downstream on every rising edge where
  // m_valid && m_ready; m_data/m_last hold while m_valid && !m_ready.

  localparam logic [7:0] BEAT_MAX = 8'(BURST - 1);

  reader_state_e    state_q, state_d;
  logic             inflight_q;
  logic [7:0]       beat_q, beat_d;
  logic [1:0]       occ;
  logic [WIDTH:0]   head;
  logic             xfer;
  logic [2:0]       used;
  logic [2:0]       limit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)                             state_d = ST_RUN;
        else if (occ == 2'd0 && !inflight_q) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      beat_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
    end
  end

  assign xfer  = m_valid && m_ready;
  assign used  = {1'b0, occ} + {2'b00, inflight_q};
  assign limit = 3'd2 + {2'b00, xfer};

  assign fifo_rd_en = !rst && (state_q == ST_RUN) && en && !fifo_empty && (used < limit);

  // Burst position is tagged as words enter the buffer; the buffer is strictly
  // in order and only loses words on reset, so this equals the transfer count.
  assign beat_d = inflight_q ? beat_next(beat_q, BEAT_MAX) : beat_q;

  fifo_reader_buf #(.W(WIDTH + 1)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({beat_q == BEAT_MAX, fifo_dout}),
    .pop_i       (xfer),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign m_valid   = !rst && (occ != 2'd0);
  assign m_data    = rst ? '0 : head[WIDTH-1:0];
  assign m_last    = m_valid && head[WIDTH];
  assign busy      = !rst && (state_q != ST_IDLE);
  assign state_dbg = state_q;

`ifdef FIFO_READER_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= 16'd0;
    else if (xfer) cnt_q <= cnt_q + 16'd1;
  end

  assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: FIFO model, directed table, hand sequences and
// randomized traffic checked against a pop-order/latency reference model.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int W     = 8;
  localparam int BURST = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         fifo_empty;
  logic [W-1:0] fifo_dout;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         busy;
  reader_state_e state_dbg;
`ifdef FIFO_READER_CNT_EN
  logic [15:0]  word_cnt;
`endif

  fifo_reader #(.WIDTH(W), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
`ifdef FIFO_READER_CNT_EN
    .word_cnt   (word_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // FIFO model and scoreboard
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         last_rd    = 1'b0;
  int           refill_pct = 0;
  int           xfer_cnt   = 0;
  int           pops       = 0;
  int           deliv      = 0;
  logic [15:0]  last_bits  = '0;
  logic         have_prev  = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic exp_valid;
    logic xfer;
    int   outstanding;
    if (rst) begin
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      exp_q.delete();
      exp_cyc_q.delete();
      xfer_cnt  = 0;
      have_prev = 1'b0;
      last_rd   = 1'b0;
    end else begin
      chk("pop_when_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      exp_valid = (exp_q.size() > 0) && (exp_cyc_q[0] + 2 <= cyc);
      chk("m_valid", 32'(m_valid), 32'(exp_valid));
      if (have_prev) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
`ifdef FIFO_READER_CNT_EN
      chk("word_cnt", 32'(word_cnt), 32'(xfer_cnt % 65536));
`endif
      xfer = m_valid && m_ready;
      if (xfer && exp_q.size() > 0) begin
        chk("m_data", 32'(m_data), 32'(exp_q[0]));
        chk("m_last", 32'(m_last), 32'((xfer_cnt % BURST) == BURST - 1));
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        if (deliv < 16) last_bits[deliv] = m_last;
        xfer_cnt++;
        deliv++;
      end
      outstanding = exp_q.size() + int'(fifo_rd_en);
      chk("outstanding_le2", 32'(outstanding <= 2), 32'd1);
      if (fifo_rd_en && fifo_q.size() > 0) begin
        exp_q.push_back(fifo_q[0]);
        exp_cyc_q.push_back(cyc);
        pops++;
      end
      have_prev = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      last_rd   = fifo_rd_en;
    end
  endtask

  // driver: one clock cycle; registered FIFO output updates just after the edge
  task automatic tick(input logic en_v, input logic rdy_v, input logic rst_v);
    @(posedge clk);
    #1;
    cyc++;
    if (last_rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    if (refill_pct > 0 && fifo_q.size() < FIFO_DEPTH_DEF && $urandom_range(99) < refill_pct)
      fifo_q.push_back(W'($urandom));
    fifo_empty = (fifo_q.size() == 0);
    en         = en_v;
    m_ready    = rdy_v;
    rst        = rst_v;
    #1;
    monitor();
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1);
    fifo_q.delete();
    tick(1'b0, 1'b0, 1'b1);
    pops      = 0;
    deliv     = 0;
    last_bits = '0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(W'($urandom));
  endtask

  typedef struct {
    logic         en;
    logic         rdy;
    logic         rd;
    logic         vld;
    logic [W-1:0] data;
    logic         last;
    logic         bsy;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic r, input logic rd, input logic v,
                              input logic [W-1:0] d, input logic l, input logic b);
    vec_t t;
    t.en = e; t.rdy = r; t.rd = rd; t.vld = v; t.data = d; t.last = l; t.bsy = b;
    return t;
  endfunction

  vec_t tbl[12];
  logic [W-1:0] first_word;

  initial begin
    tbl[0]  = mk(1, 1, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
    tbl[2]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
    tbl[3]  = mk(1, 1, 1, 1, 8'h11, 0, 1);
    tbl[4]  = mk(1, 1, 1, 1, 8'h12, 0, 1);
    tbl[5]  = mk(1, 1, 1, 1, 8'h13, 0, 1);
    tbl[6]  = mk(1, 1, 1, 1, 8'h14, 1, 1);
    tbl[7]  = mk(1, 1, 1, 1, 8'h15, 0, 1);
    tbl[8]  = mk(1, 1, 1, 1, 8'h16, 0, 1);
    tbl[9]  = mk(1, 1, 0, 1, 8'h17, 0, 1);
    tbl[10] = mk(1, 1, 0, 1, 8'h18, 1, 1);
    tbl[11] = mk(1, 1, 0, 0, 8'h00, 0, 1);

    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;

    // reset held with run requested and a non-empty FIFO
    load(3);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));

    // streaming table: 0x11..0x18 at full throughput
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(W'(8'h11 + i));
    pops = 0; deliv = 0; last_bits = '0;
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].en, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].data));
        chk($sformatf("tbl%0d_last", i), 32'(m_last), 32'(tbl[i].last));
      end
    end

    // backpressure: 5 words, downstream stalled for 6 cycles
    do_reset();
    load(5);
    first_word = fifo_q[0];
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
    chk("bp_pops", 32'(pops), 32'd2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'(first_word));
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0);
    chk("bp_delivered", 32'(deliv), 32'd5);
    chk("bp_pops_total", 32'(pops), 32'd5);
    chk("bp_none_left", 32'(exp_q.size()), 32'd0);

    // empty boundary: single word
    do_reset();
    load(1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0);
    chk("one_pops", 32'(pops), 32'd1);
    chk("one_delivered", 32'(deliv), 32'd1);

    // drain: en dropped with one word buffered and one in flight
    do_reset();
    load(5);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("drain_busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
    chk("drain_pops", 32'(pops), 32'd2);
    chk("drain_delivered", 32'(deliv), 32'd2);
    chk("drain_busy_end", 32'(busy), 32'd0);
    chk("drain_state", 32'(state_dbg), 32'(ST_IDLE));

    // burst wrap: 9 words, last on words 4 and 8
    do_reset();
    load(9);
    for (int i = 0; i < 14; i++) tick(1'b1, 1'b1, 1'b0);
    chk("burst_delivered", 32'(deliv), 32'd9);
    chk("burst_last_bits", 32'(last_bits[8:0]), 32'h088);
`ifdef FIFO_READER_CNT_EN
    chk("burst_word_cnt", 32'(word_cnt), 32'd9);
`endif

    // randomized traffic with en toggling, stalls, refills and rare resets
    do_reset();
    refill_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end
    refill_pct = 0;
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 1'b0);
    chk("rand_all_delivered", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
